rc4_xor_stage: RTL and testbench
================================

Name: rc4_xor_stage

Overview:
Downstream consumer of the RC4 PRGA keystream. Buffers keystream bytes in a small FIFO, because the generator cannot be stalled. XORs each buffered byte with one incoming data byte through a valid/ready handshake and presents the result on a registered output. Sits between the rc4 keystream generator and the byte-stream datapath; it is the encrypt/decrypt combiner.

Parameters:
FIFO_DEPTH, 16, keystream FIFO depth in bytes; power of two, minimum 2.
AW, 4, log2(FIFO_DEPTH); pointer width.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous flush; empties FIFO, clears error, returns to RUN
ks_valid  input  1  keystream byte present this cycle (driven by rc4 output_ready)
ks_byte  input  8  keystream byte (driven by rc4 K)
din_valid  input  1  data byte offered
din  input  8  plaintext/ciphertext byte
din_ready  output  1  stage accepts din this cycle
dout_valid  output  1  result byte valid
dout  output  8  din XOR keystream
dout_ready  input  1  downstream accepts dout
ks_level  output  AW+1  FIFO occupancy, 0..FIFO_DEPTH
ks_overflow  output  1  sticky; a keystream byte was dropped

Behaviour:
- Reset (async, rst=1): FIFO pointers=0, ks_level=0, dout_valid=0, dout=8'h00, ks_overflow=0, state=RUN.
- Keystream capture: each clk cycle with ks_valid=1 is one byte. No edge detection; rc4 holds output_ready high for exactly one cycle per byte.
  - Push when ks_valid=1 and (not full, or a pop occurs the same cycle).
  - ks_valid=1 with FIFO full and no pop: byte dropped, ks_overflow<=1, state<=HALT.
- FIFO has no read-through. A byte pushed in cycle N is poppable from cycle N+1. A simultaneous push and pop on an empty FIFO is impossible, because pop requires non-empty.
- FSM states:
  - RUN: normal operation.
  - HALT: keystream sync lost. din_ready=0. dout may still drain. FIFO keeps accepting ks bytes while space remains; further overflows are ignored (flag already set).
  - Transitions: RUN->HALT on overflow. HALT->RUN only on clear. Reset goes to RUN.
- din_ready = (state==RUN) and FIFO not empty and (dout_valid=0 or dout_ready=1). It is combinational from registered state and dout_ready.
- Transfer occurs when din_valid and din_ready. On transfer:
  - Pop the FIFO head.
  - dout <= din XOR head.
  - dout_valid <= 1.
  - Latency: 1 clk from acceptance to dout_valid.
- Without a transfer, dout_ready=1 clears dout_valid. With dout_valid=1 and dout_ready=0, dout and dout_valid hold stable.
- Throughput: 1 byte/clk while the FIFO is non-empty. The rc4 source delivers at most 1 byte per 2 clk, so steady-state is keystream-limited.
- ks_level: +1 on push, -1 on pop, unchanged on simultaneous push+pop. Pointers wrap modulo FIFO_DEPTH.
- clear (sync) has priority over all other events in the same cycle:
  - Pointers=0, ks_level=0, ks_overflow=0, dout_valid=0, state=RUN.
  - A ks_valid byte in the clear cycle is discarded.
  - The keystream consumer must re-key rc4 after clear.
- Reset mid-transfer: all state is lost immediately; dout_valid drops asynchronously.
- No arithmetic beyond the 8-bit XOR. Pointer and level arithmetic is unsigned, and level never exceeds FIFO_DEPTH.

Optional Feature:
RC4X_BYTE_COUNT_EN
- Defined: adds output byte_count [31:0].
  - Reset and clear set it to 0.
  - It increments by 1 on every din transfer and wraps at 2^32.
  - It is not incremented in HALT.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, push ks bytes 8'hA5, 8'h3C (one cycle apart, ks_valid pulses). Then offer din 8'hFF, 8'h00 with dout_ready=1 -> dout 8'h5A then 8'h3C, each 1 clk after acceptance. ks_level 2->0.
2. Offer din_valid=1 with FIFO empty -> din_ready=0, dout_valid stays 0. Push ks 8'h11 in cycle N -> din_ready=1 in N+1, dout=din^8'h11 in N+2.
3. Hold dout_ready=0 after one transfer -> din_ready=0, dout stable for 5 cycles. Release -> next byte accepted in the same cycle dout_ready=1.
4. Fill FIFO with 16 bytes, then send ks_valid with no pop -> ks_overflow=1, state HALT, din_ready=0, ks_level=16. Pulse clear -> ks_level=0, ks_overflow=0, din_ready=0 until the next push.
5. FIFO full (16) with a ks_valid push and din transfer in the same cycle -> no overflow, ks_level stays 16, dout correct.
6. With RC4X_BYTE_COUNT_EN defined: perform 300 transfers -> byte_count=300. Assert rst mid-stream -> byte_count=0 and dout_valid=0 immediately.

Source files
------------

// File: rtl/rc4_xor_stage.sv
// rtl/rc4_xor_stage.sv - RC4 keystream FIFO and data XOR combiner with registered output
// Optional feature macro: RC4X_BYTE_COUNT_EN (adds byte_count output)
module rc4_xor_stage #(
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          ks_valid,
  input  logic [7:0]    ks_byte,
  input  logic          din_valid,
  input  logic [7:0]    din,
  output logic          din_ready,
  output logic          dout_valid,
  output logic [7:0]    dout,
  input  logic          dout_ready,
  output logic [AW:0]   ks_level,
  output logic          ks_overflow
`ifdef RC4X_BYTE_COUNT_EN
  ,
  output logic [31:0]   byte_count
`endif
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              push;
  logic              ovf_evt;

  assign fifo_full  = (ks_level == LVL_FULL);
  assign fifo_empty = (ks_level == '0);

  // The generator cannot be stalled, so a pop in the same cycle frees the slot for a full-FIFO push.
  assign xfer    = din_valid && din_ready;
  assign push    = ks_valid && (!fifo_full || xfer);
  assign ovf_evt = ks_valid && fifo_full && !xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (ovf_evt) state_d = ST_HALT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    din_ready = 1'b0;
    case (state_q)
      ST_RUN:  din_ready = !fifo_empty && (!dout_valid || dout_ready);
      ST_HALT: din_ready = 1'b0;
      default: din_ready = 1'b0;
    endcase
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= ks_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ks_level <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ks_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, xfer})
        2'b10:   ks_level <= ks_level + LVL_ONE;
        2'b01:   ks_level <= ks_level - LVL_ONE;
        default: ks_level <= ks_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_overflow <= 1'b0;
    end else if (clear) begin
      ks_overflow <= 1'b0;
    end else if (ovf_evt) begin
      ks_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= 8'h00;
    end else if (clear) begin
      dout_valid <= 1'b0;
    end else if (xfer) begin
      dout_valid <= 1'b1;
      dout       <= din ^ mem[rd_ptr];
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef RC4X_BYTE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= 32'd0;
    end else if (clear) begin
      byte_count <= 32'd0;
    end else if (xfer && (state_q == ST_RUN)) begin
      byte_count <= byte_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rc4_xor_stage.sv
// tb/tb_rc4_xor_stage.sv - self-checking bench for rc4_xor_stage
module tb_rc4_xor_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        ks_valid;
  logic [7:0]  ks_byte;
  logic        din_valid;
  logic [7:0]  din;
  logic        din_ready;
  logic        dout_valid;
  logic [7:0]  dout;
  logic        dout_ready;
  logic [4:0]  ks_level;
  logic        ks_overflow;
`ifdef RC4X_BYTE_COUNT_EN
  logic [31:0] byte_count;
`endif

  int total = 0;
  int bad   = 0;

  rc4_xor_stage #(.FIFO_DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .ks_valid    (ks_valid),
    .ks_byte     (ks_byte),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready),
    .dout_valid  (dout_valid),
    .dout        (dout),
    .dout_ready  (dout_ready),
    .ks_level    (ks_level),
    .ks_overflow (ks_overflow)
`ifdef RC4X_BYTE_COUNT_EN
    ,
    .byte_count  (byte_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (now=%0t required<2000000)", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ks(input logic [7:0] b);
    ks_valid = 1'b1;
    ks_byte  = b;
    tick();
    ks_valid = 1'b0;
  endtask

  task automatic do_clear();
    din_valid = 1'b0;
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; ks_valid = 1'b0; ks_byte = 8'h00;
    din_valid = 1'b0; din = 8'h00; dout_ready = 1'b0;
    repeat (3) tick();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (ks_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", ks_level); end
    total++; if (ks_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", ks_overflow); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_din_ready got=%b exp=0", din_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push_ks(8'hA5);
    tick();
    push_ks(8'h3C);
    total++; if (ks_level !== 5'd2) begin bad++; $display("FAIL basic_level2 got=%0d exp=2", ks_level); end
    din_valid = 1'b1; din = 8'hFF; dout_ready = 1'b1;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", din_ready); end
    tick();
    total++; if (dout_valid !== 1'b1 || dout !== 8'h5A) begin bad++; $display("FAIL basic_dout1 got=%b/%h exp=1/5a", dout_valid, dout); end
    total++; if (ks_level !== 5'd1) begin bad++; $display("FAIL basic_level1 got=%0d exp=1", ks_level); end
    din = 8'h00;
    tick();
    total++; if (dout_valid !== 1'b1 || dout !== 8'h3C) begin bad++; $display("FAIL basic_dout2 got=%b/%h exp=1/3c", dout_valid, dout); end
    total++; if (ks_level !== 5'd0) begin bad++; $display("FAIL basic_level0 got=%0d exp=0", ks_level); end
    din_valid = 1'b0;
    tick();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", dout_valid); end
  endtask

  task automatic test_empty();
    din_valid = 1'b1; din = 8'h42; dout_ready = 1'b1;
    #1;
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL empty_ready got=%b exp=0", din_ready); end
    tick();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL empty_dout_valid got=%b exp=0", dout_valid); end
    ks_valid = 1'b1; ks_byte = 8'h11;
    #1;
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL empty_no_readthrough got=%b exp=0", din_ready); end
    tick();
    ks_valid = 1'b0;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL empty_ready_n1 got=%b exp=1", din_ready); end
    tick();
    total++; if (dout_valid !== 1'b1 || dout !== 8'h53) begin bad++; $display("FAIL empty_dout got=%b/%h exp=1/53", dout_valid, dout); end
    din_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] r1, r2, d1, d2;
    r1 = 8'($urandom); r2 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    push_ks(r1);
    push_ks(r2);
    din_valid = 1'b1; din = d1; dout_ready = 1'b0;
    tick();
    total++; if (dout_valid !== 1'b1 || dout !== (d1 ^ r1)) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/%h", dout_valid, dout, d1 ^ r1); end
    din = d2;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_held cyc=%0d got=%b exp=0", i, din_ready); end
      tick();
      total++; if (dout_valid !== 1'b1 || dout !== (d1 ^ r1)) begin bad++; $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/%h", i, dout_valid, dout, d1 ^ r1); end
    end
    dout_ready = 1'b1;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", din_ready); end
    tick();
    total++; if (dout_valid !== 1'b1 || dout !== (d2 ^ r2)) begin bad++; $display("FAIL bp_second got=%b/%h exp=1/%h", dout_valid, dout, d2 ^ r2); end
    din_valid = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push_ks(8'(i * 17 + 3));
    total++; if (ks_level !== 5'd16 || ks_overflow !== 1'b0) begin bad++; $display("FAIL ovf_full got=%0d/%b exp=16/0", ks_level, ks_overflow); end
    push_ks(8'hEE);
    total++; if (ks_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ks_overflow); end
    total++; if (ks_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", ks_level); end
    din_valid = 1'b1; din = 8'h01; dout_ready = 1'b1;
    #1;
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL ovf_halt_ready got=%b exp=0", din_ready); end
    tick();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ovf_halt_dout got=%b exp=0", dout_valid); end
    din_valid = 1'b0;
    clear = 1'b1; ks_valid = 1'b1; ks_byte = 8'h99;
    tick();
    clear = 1'b0; ks_valid = 1'b0;
    #1;
    total++; if (ks_level !== 5'd0 || ks_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0d/%b exp=0/0", ks_level, ks_overflow); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL ovf_clear_ready got=%b exp=0", din_ready); end
    push_ks(8'h77);
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL ovf_run_again got=%b exp=1", din_ready); end
    do_clear();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] kq[$];
    logic [7:0] b, d;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      kq.push_back(b);
      push_ks(b);
    end
    d = 8'($urandom);
    ks_valid = 1'b1; ks_byte = 8'($urandom); din_valid = 1'b1; din = d; dout_ready = 1'b1;
    #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL full_pp_ready got=%b exp=1", din_ready); end
    tick();
    ks_valid = 1'b0; din_valid = 1'b0;
    total++; if (ks_overflow !== 1'b0 || ks_level !== 5'd16) begin bad++; $display("FAIL full_pp_state got=%b/%0d exp=0/16", ks_overflow, ks_level); end
    total++; if (dout_valid !== 1'b1 || dout !== (d ^ kq[0])) begin bad++; $display("FAIL full_pp_dout got=%b/%h exp=1/%h", dout_valid, dout, d ^ kq[0]); end
    do_clear();
  endtask

  task automatic test_random();
    logic [7:0] mq[$];
    logic       m_ovf, m_halt, m_dv, exp_ready, xf;
    logic [7:0] m_dout, k;
    int         p;
`ifdef RC4X_BYTE_COUNT_EN
    logic [31:0] m_cnt = 32'd0;
`endif
    do_clear();
    m_ovf = 1'b0; m_halt = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      p          = ((cyc / 250) % 2 == 1) ? 75 : 30;
      clear      = ($urandom_range(0, 299) == 0);
      ks_valid   = ($urandom_range(0, 99) < p);
      ks_byte    = 8'($urandom);
      din_valid  = ($urandom_range(0, 99) < 75);
      din        = 8'($urandom);
      dout_ready = ($urandom_range(0, 99) < 70);
      #1;
      exp_ready = !m_halt && (mq.size() > 0) && (!m_dv || dout_ready);
      total++; if (din_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, din_ready, exp_ready); end
      if (clear) begin
        mq.delete(); m_ovf = 1'b0; m_halt = 1'b0; m_dv = 1'b0;
`ifdef RC4X_BYTE_COUNT_EN
        m_cnt = 32'd0;
`endif
      end else begin
        xf = din_valid && exp_ready;
        if (xf) begin
          k = mq.pop_front();
          m_dout = din ^ k;
          m_dv = 1'b1;
`ifdef RC4X_BYTE_COUNT_EN
          m_cnt++;
`endif
        end else if (dout_ready) begin
          m_dv = 1'b0;
        end
        if (ks_valid) begin
          if (mq.size() < 16) mq.push_back(ks_byte);
          else begin m_ovf = 1'b1; m_halt = 1'b1; end
        end
      end
      tick();
      total++; if (dout_valid !== m_dv) begin bad++; $display("FAIL rnd_dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, m_dv); end
      if (m_dv) begin
        total++; if (dout !== m_dout) begin bad++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", cyc, dout, m_dout); end
      end
      total++; if (int'(ks_level) !== mq.size()) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, ks_level, mq.size()); end
      total++; if (ks_overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", cyc, ks_overflow, m_ovf); end
`ifdef RC4X_BYTE_COUNT_EN
      total++; if (byte_count !== m_cnt) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, byte_count, m_cnt); end
`endif
    end
    clear = 1'b0; ks_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    do_clear();
  endtask

  task automatic test_count_and_async_reset();
    logic [7:0] kq[$];
    logic [7:0] b, e;
    do_clear();
    dout_ready = 1'b1;
    b = 8'($urandom); kq.push_back(b);
    push_ks(b);
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom); kq.push_back(b);
      ks_valid = 1'b1; ks_byte = b;
      din_valid = 1'b1; din = 8'($urandom);
      e = din ^ kq.pop_front();
      tick();
      total++; if (dout_valid !== 1'b1 || dout !== e) begin bad++; $display("FAIL stream_dout i=%0d got=%b/%h exp=1/%h", i, dout_valid, dout, e); end
    end
    ks_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    total++; if (ks_level !== 5'd1) begin bad++; $display("FAIL stream_level got=%0d exp=1", ks_level); end
`ifdef RC4X_BYTE_COUNT_EN
    total++; if (byte_count !== 32'd300) begin bad++; $display("FAIL count_300 got=%0d exp=300", byte_count); end
`endif
    #3;
    rst = 1'b1;
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%b exp=0", dout_valid); end
    total++; if (ks_level !== 5'd0 || dout !== 8'h00) begin bad++; $display("FAIL async_rst_state got=%0d/%h exp=0/00", ks_level, dout); end
`ifdef RC4X_BYTE_COUNT_EN
    total++; if (byte_count !== 32'd0) begin bad++; $display("FAIL async_rst_count got=%0d exp=0", byte_count); end
`endif
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_count_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
